// File: rtl/isa_cycle_master_if.sv
// ISA cycle master port bundle: request handshake, completion status and ISA bus pins.
// Latency: none, wires only.
// Backpressure: none here; the master ignores req while busy, and bus_rdy stretches the strobe.
interface isa_cycle_master_if;
    logic        req;
    logic        req_io;
    logic        req_write;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  rdata;
    logic [19:0] bus_a;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [7:0]  bus_d_in;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic        bus_aen;
    logic        bus_rdy;

    modport master (
        input  req, req_io, req_write, req_addr, req_wdata, bus_d_in, bus_rdy,
        output busy, done, timeout, rdata, bus_a, bus_d_out, bus_d_oe,
               bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
    );

    modport slave (
        output req, req_io, req_write, req_addr, req_wdata, bus_d_in, bus_rdy,
        input  busy, done, timeout, rdata, bus_a, bus_d_out, bus_d_oe,
               bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
    );
endinterface

// File: rtl/isa_cycle_master.sv
// Runs one ISA I/O or memory read/write cycle (setup, strobe, wait, hold) per accepted request.
// Latency: done 1+SETUP+STROBE+HOLD cycles after accept, plus one per wait cycle.
// Backpressure: req is only sampled in IDLE; bus_rdy low stretches the strobe up to TIMEOUT cycles.
module isa_cycle_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic clk,
    input  logic reset_l,
    isa_cycle_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    // Terminal counts; the phase counter restarts at 0 on every phase entry.
    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        io_q, io_d;
    logic        wr_q, wr_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        to_flag_q, to_flag_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic [7:0]  bus_d_out_q, bus_d_out_d;
    logic        bus_d_oe_q, bus_d_oe_d;
    logic        ior_l_q, ior_l_d;
    logic        iow_l_q, iow_l_d;
    logic        memr_l_q, memr_l_d;
    logic        memw_l_q, memw_l_d;
    logic        aen_q, aen_d;
    logic        capture;
    logic        strobe_on;
    logic        active;

    // Next-state, phase counting, and bus pin values derived from the next state so every pin is a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        io_d      = io_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        to_flag_d = to_flag_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    io_d      = bus.req_io;
                    wr_d      = bus.req_write;
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    to_flag_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d = 8'd0;
                    if (bus.bus_rdy) begin
                        state_d = S_HOLD;
                        capture = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (bus.bus_rdy) begin
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                    capture = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Responder never became ready: finish anyway and flag it.
                    cnt_d     = 8'd0;
                    state_d   = S_HOLD;
                    capture   = 1'b1;
                    to_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d     = 8'd0;
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    timeout_d = to_flag_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase

        // Read data is taken on the edge that ends the last strobe-low cycle.
        if (capture && !wr_q) begin
            rdata_d = bus.bus_d_in;
        end

        strobe_on   = (state_d == S_STROBE) || (state_d == S_WAIT);
        active      = (state_d != S_IDLE);
        busy_d      = active;
        aen_d       = !active;
        bus_a_d     = active ? addr_d : 20'd0;
        bus_d_out_d = active ? wdata_d : 8'd0;
        bus_d_oe_d  = active && wr_d;
        ior_l_d     = !(strobe_on &&  io_d && !wr_d);
        iow_l_d     = !(strobe_on &&  io_d &&  wr_d);
        memr_l_d    = !(strobe_on && !io_d && !wr_d);
        memw_l_d    = !(strobe_on && !io_d &&  wr_d);
    end

    // State and registered outputs; reset parks the bus idle with all strobes released.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            io_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 20'd0;
            wdata_q     <= 8'd0;
            to_flag_q   <= 1'b0;
            rdata_q     <= 8'd0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            bus_a_q     <= 20'd0;
            bus_d_out_q <= 8'd0;
            bus_d_oe_q  <= 1'b0;
            ior_l_q     <= 1'b1;
            iow_l_q     <= 1'b1;
            memr_l_q    <= 1'b1;
            memw_l_q    <= 1'b1;
            aen_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            io_q        <= io_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            to_flag_q   <= to_flag_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            bus_a_q     <= bus_a_d;
            bus_d_out_q <= bus_d_out_d;
            bus_d_oe_q  <= bus_d_oe_d;
            ior_l_q     <= ior_l_d;
            iow_l_q     <= iow_l_d;
            memr_l_q    <= memr_l_d;
            memw_l_q    <= memw_l_d;
            aen_q       <= aen_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.rdata      = rdata_q;
    assign bus.bus_a      = bus_a_q;
    assign bus.bus_d_out  = bus_d_out_q;
    assign bus.bus_d_oe   = bus_d_oe_q;
    assign bus.bus_ior_l  = ior_l_q;
    assign bus.bus_iow_l  = iow_l_q;
    assign bus.bus_memr_l = memr_l_q;
    assign bus.bus_memw_l = memw_l_q;
    assign bus.bus_aen    = aen_q;

endmodule

// File: tb/tb_isa_cycle_master.sv
// Directed bench for isa_cycle_master: default-timing instance plus a TIMEOUT=4 instance.
// Latency: expected per-cycle pin timeline built from cycle index relative to the accepting edge.
// Backpressure: bus_rdy driven low for chosen wait windows or stuck low to force a timeout.
module tb_isa_cycle_master;

    logic clk = 1'b0;
    logic reset_l;

    always #5 clk = ~clk;

    isa_cycle_master_if ifc ();
    isa_cycle_master_if ifc2 ();

    isa_cycle_master dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (ifc)
    );

    isa_cycle_master #(.TIMEOUT(4)) dut2 (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (ifc2)
    );

    // Shared stimulus; sel2 steers req and observation to the second instance.
    logic        sel2;
    logic        req_drv;
    logic        io_drv;
    logic        wr_drv;
    logic [19:0] addr_drv;
    logic [7:0]  wd_drv;
    logic [7:0]  din_drv;
    logic        rdy_drv;

    assign ifc.req        = req_drv & ~sel2;
    assign ifc2.req       = req_drv & sel2;
    assign ifc.req_io     = io_drv;
    assign ifc2.req_io    = io_drv;
    assign ifc.req_write  = wr_drv;
    assign ifc2.req_write = wr_drv;
    assign ifc.req_addr   = addr_drv;
    assign ifc2.req_addr  = addr_drv;
    assign ifc.req_wdata  = wd_drv;
    assign ifc2.req_wdata = wd_drv;
    assign ifc.bus_d_in   = din_drv;
    assign ifc2.bus_d_in  = din_drv;
    assign ifc.bus_rdy    = rdy_drv;
    assign ifc2.bus_rdy   = rdy_drv;

    logic        o_busy, o_done, o_to, o_doe, o_ior, o_iow, o_memr, o_memw, o_aen;
    logic [7:0]  o_rdata, o_dout;
    logic [19:0] o_a;

    always_comb begin
        o_busy  = sel2 ? ifc2.busy       : ifc.busy;
        o_done  = sel2 ? ifc2.done       : ifc.done;
        o_to    = sel2 ? ifc2.timeout    : ifc.timeout;
        o_rdata = sel2 ? ifc2.rdata      : ifc.rdata;
        o_a     = sel2 ? ifc2.bus_a      : ifc.bus_a;
        o_dout  = sel2 ? ifc2.bus_d_out  : ifc.bus_d_out;
        o_doe   = sel2 ? ifc2.bus_d_oe   : ifc.bus_d_oe;
        o_ior   = sel2 ? ifc2.bus_ior_l  : ifc.bus_ior_l;
        o_iow   = sel2 ? ifc2.bus_iow_l  : ifc.bus_iow_l;
        o_memr  = sel2 ? ifc2.bus_memr_l : ifc.bus_memr_l;
        o_memw  = sel2 ? ifc2.bus_memw_l : ifc.bus_memw_l;
        o_aen   = sel2 ? ifc2.bus_aen    : ifc.bus_aen;
    end

    typedef struct {
        logic [7:0] rdata;
        logic       to;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_rdata [2];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Parameters of the request chained onto the done cycle.
    logic        nxt_io, nxt_wr;
    logic [19:0] nxt_addr;
    logic [7:0]  nxt_wd, nxt_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [7:0] din, input logic to);
        exp_t e;
        e.rdata = wr ? model_rdata[sel2] : din;
        e.to    = to;
        if (!wr) model_rdata[sel2] = din;
        sb.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".busy"}, 32'(o_busy), 32'd0);
        chk({nm, ".done"}, 32'(o_done), 32'd0);
        chk({nm, ".to"},   32'(o_to),   32'd0);
        chk({nm, ".a"},    32'(o_a),    32'd0);
        chk({nm, ".doe"},  32'(o_doe),  32'd0);
        chk({nm, ".aen"},  32'(o_aen),  32'd1);
        chk({nm, ".strb"}, 32'({o_ior, o_iow, o_memr, o_memw}), 32'hF);
    endtask

    // One complete cycle, checked every clock against the expected pin timeline.
    task automatic run(input string nm, input logic io, input logic wr, input logic [19:0] addr,
                       input logic [7:0] wd, input logic [7:0] din, input int waits,
                       input bit stuck, input bit pre, input int pulse_k, input bit chain);
        int   total;
        int   last_strobe;
        logic strobe;
        logic act;
        exp_t e;
        total       = 8 + waits;
        last_strobe = 6 + waits;
        if (!pre) begin
            @(negedge clk);
            io_drv   = io;
            wr_drv   = wr;
            addr_drv = addr;
            wd_drv   = wd;
            req_drv  = 1'b1;
            push_exp(wr, din, stuck);
        end
        @(posedge clk);
        #1;
        req_drv  = 1'b0;
        // Scramble request fields so any failure to latch shows up on the bus.
        io_drv   = ~io;
        wr_drv   = ~wr;
        addr_drv = ~addr;
        wd_drv   = ~wd;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            rdy_drv = !(k >= 6 && (stuck || k < 6 + waits));
            din_drv = (k >= 3 && k <= last_strobe) ? din : ~din;
            if (pulse_k != 0 && k == pulse_k) req_drv = 1'b1;
            if (pulse_k != 0 && k == pulse_k + 1) req_drv = 1'b0;
            strobe = (k >= 3 && k <= last_strobe);
            act    = (k < total);
            chk({nm, ".busy"}, 32'(o_busy), 32'(act));
            chk({nm, ".done"}, 32'(o_done), 32'(k == total));
            chk({nm, ".aen"},  32'(o_aen),  32'(!act));
            chk({nm, ".doe"},  32'(o_doe),  32'(act && wr));
            chk({nm, ".a"},    32'(o_a),    act ? 32'(addr) : 32'd0);
            if (act) chk({nm, ".dout"}, 32'(o_dout), 32'(wd));
            chk({nm, ".ior"},  32'(o_ior),  32'(!(strobe &&  io && !wr)));
            chk({nm, ".iow"},  32'(o_iow),  32'(!(strobe &&  io &&  wr)));
            chk({nm, ".memr"}, 32'(o_memr), 32'(!(strobe && !io && !wr)));
            chk({nm, ".memw"}, 32'(o_memw), 32'(!(strobe && !io &&  wr)));
            if (k < total) begin
                chk({nm, ".to"}, 32'(o_to), 32'd0);
            end else begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL %s.sb observed=empty expected=entry", nm);
                end else begin
                    e = sb.pop_front();
                    chk({nm, ".rdata"}, 32'(o_rdata), 32'(e.rdata));
                    chk({nm, ".to"},    32'(o_to),    32'(e.to));
                end
                if (chain) begin
                    io_drv   = nxt_io;
                    wr_drv   = nxt_wr;
                    addr_drv = nxt_addr;
                    wd_drv   = nxt_wd;
                    req_drv  = 1'b1;
                    push_exp(nxt_wr, nxt_din, 1'b0);
                end
            end
        end
        rdy_drv = 1'b1;
    endtask

    initial begin
        sel2           = 1'b0;
        req_drv        = 1'b0;
        io_drv         = 1'b0;
        wr_drv         = 1'b0;
        addr_drv       = 20'd0;
        wd_drv         = 8'd0;
        din_drv        = 8'd0;
        rdy_drv        = 1'b1;
        model_rdata[0] = 8'd0;
        model_rdata[1] = 8'd0;
        reset_l        = 1'b0;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst.rdata", 32'(o_rdata), 32'd0);
        chk("rst.dout",  32'(o_dout),  32'd0);
        sel2 = 1'b1;
        #1;
        chk_idle("rst2");
        chk("rst2.rdata", 32'(o_rdata), 32'd0);
        sel2 = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;

        // I/O write, I/O read, memory read with five wait states.
        run("iow",  1'b1, 1'b1, 20'h003D8, 8'h29, 8'h00, 0, 1'b0, 1'b0, 0, 1'b0);
        run("ior",  1'b1, 1'b0, 20'h003DA, 8'h00, 8'hF9, 0, 1'b0, 1'b0, 0, 1'b0);
        run("memr", 1'b0, 1'b0, 20'hB8000, 8'h00, 8'h3C, 5, 1'b0, 1'b0, 0, 1'b0);

        // Request pulsed mid-cycle is dropped; request held at done chains a memory write.
        nxt_io   = 1'b0;
        nxt_wr   = 1'b1;
        nxt_addr = 20'hA0000;
        nxt_wd   = 8'h77;
        nxt_din  = 8'h00;
        run("b2b_a", 1'b1, 1'b0, 20'h00060, 8'h00, 8'hC3, 0, 1'b0, 1'b0, 4, 1'b1);
        run("b2b_b", 1'b0, 1'b1, 20'hA0000, 8'h77, 8'h00, 0, 1'b0, 1'b1, 0, 1'b0);

        // Reset during the strobe of a memory write aborts it with no done.
        @(negedge clk);
        io_drv   = 1'b0;
        wr_drv   = 1'b1;
        addr_drv = 20'hC0000;
        wd_drv   = 8'h5E;
        req_drv  = 1'b1;
        @(posedge clk);
        #1;
        req_drv = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort.memw_pre", 32'(o_memw), 32'd0);
        chk("abort.aen_pre",  32'(o_aen),  32'd0);
        reset_l = 1'b0;
        #1;
        chk("abort.memw",  32'(o_memw),  32'd1);
        chk("abort.aen",   32'(o_aen),   32'd1);
        chk("abort.busy",  32'(o_busy),  32'd0);
        chk("abort.doe",   32'(o_doe),   32'd0);
        chk("abort.a",     32'(o_a),     32'd0);
        chk("abort.rdata", 32'(o_rdata), 32'd0);
        model_rdata[0] = 8'd0;
        model_rdata[1] = 8'd0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort.nodone", 32'(o_done), 32'd0);
        end
        run("post_rst", 1'b0, 1'b1, 20'hC0000, 8'h5E, 8'h00, 0, 1'b0, 1'b0, 0, 1'b0);

        // Stuck bus_rdy on the TIMEOUT=4 instance, then a normal read to show recovery.
        sel2 = 1'b1;
        run("tmo",      1'b0, 1'b0, 20'hD0000, 8'h00, 8'h5A, 4, 1'b1, 1'b0, 0, 1'b0);
        run("tmo_next", 1'b1, 1'b0, 20'h00300, 8'h00, 8'h81, 0, 1'b0, 1'b0, 0, 1'b0);
        sel2 = 1'b0;
        #1;

        chk("sb.left", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
